// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg
// Shared definitions for the sequential arithmetic blocks (seq_mul today,
// a sequential divider later).
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - clog2 constant function used to size iteration counters
package seq_mul_pkg;

  typedef logic [1:0] state_t;

  // Encoding 2'd3 is unused; every FSM built on these decodes it as IDLE.
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Ceiling log2, usable in parameter and localparam expressions.
  // clog2(1) = 0, clog2(8) = 3, clog2(9) = 4.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if
// Request/response bundle for the sequential multiplier.
//   start  requester -> multiplier  request, honoured only when not busy
//   a, b   requester -> multiplier  unsigned operands, sampled with start
//   busy   multiplier -> requester  a multiply is in progress
//   done   multiplier -> requester  one-cycle pulse, prod is new
//   prod   multiplier -> requester  registered 2*DATAWIDTH product
// master = requester side, slave = multiplier side.
interface seq_mul_if #(
  parameter int DATAWIDTH = 8
);

  logic                     start;
  logic [DATAWIDTH-1:0]     a;
  logic [DATAWIDTH-1:0]     b;
  logic                     busy;
  logic                     done;
  logic [2*DATAWIDTH-1:0]   prod;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  prod
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output prod
  );

endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl
// Control path of the shift-add multiplier: IDLE/RUN/DONE state machine plus
// the iteration counter.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request from the requester
//   load      out  capture operands and clear the accumulator this edge
//   shift_en  out  perform one add/shift iteration this edge
//   last      out  this iteration is the final one; product is registered
//   busy      out  high in RUN only
//   done      out  high in DONE only (exactly one cycle per result)
module seq_mul_ctrl #(
  parameter int DATAWIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift_en,
  output logic last,
  output logic busy,
  output logic done
);

  import seq_mul_pkg::*;

  // One extra bit so the counter reaches DATAWIDTH without wrapping.
  localparam int              CW         = clog2(DATAWIDTH) + 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(DATAWIDTH - 1);

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;

  // Operands are accepted from IDLE, from DONE (back-to-back) and from the
  // unused encoding, which behaves exactly like IDLE. Never from RUN.
  assign load     = start && (state_reg != ST_RUN);
  assign shift_en = (state_reg == ST_RUN);
  assign last     = shift_en && (count_reg == LAST_COUNT);
  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count_reg == LAST_COUNT) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_next = start ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = '0;
    end else if (shift_en) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/seq_mul.sv
// seq_mul
// Multi-cycle shift-add unsigned multiplier. Operands are captured on a start
// request; DATAWIDTH iterations later the full 2*DATAWIDTH product is
// registered and flagged by a one-cycle done. Fixed latency, no early-out.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset; clears all state and prod
//   bus    slave side of seq_mul_if (start, a, b, busy, done, prod)
module seq_mul #(
  parameter int DATAWIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_mul_if.slave  bus
);

  localparam int W = DATAWIDTH;

  logic              load;
  logic              shift_en;
  logic              last;

  logic [W-1:0]      mcand_reg;
  logic [W-1:0]      acc_reg;
  logic [W-1:0]      mplier_reg;
  logic [2*W-1:0]    prod_reg;

  logic [W-1:0]      addend;
  logic [W:0]        sum;
  logic [W-1:0]      acc_next;
  logic [W-1:0]      mplier_next;

  seq_mul_ctrl #(
    .DATAWIDTH (W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.start),
    .load     (load),
    .shift_en (shift_en),
    .last     (last),
    .busy     (bus.busy),
    .done     (bus.done)
  );

  // Partial product for this iteration: mcand gated by the multiplier LSB.
  for (genvar gi = 0; gi < W; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
  end

  // W+1 bit adder keeps the carry, which becomes the top bit of acc after
  // the right shift of {carry, acc, mplier}. The multiplier bits shift out
  // at the bottom while product bits fill in from above.
  assign sum         = {1'b0, acc_reg} + {1'b0, addend};
  assign acc_next    = sum[W:1];
  assign mplier_next = {sum[0], mplier_reg[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
    end else if (load) begin
      mcand_reg  <= bus.a;
      acc_reg    <= '0;
      mplier_reg <= bus.b;
    end else if (shift_en) begin
      acc_reg    <= acc_next;
      mplier_reg <= mplier_next;
    end
  end

  // prod is written only on the edge that enters DONE, directly from the
  // final iteration's shifted value, so it holds steady between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg <= '0;
    end else if (last) begin
      prod_reg <= {acc_next, mplier_next};
    end
  end

  assign bus.prod = prod_reg;

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_if #(.DATAWIDTH(8))  bus8 ();
  seq_mul_if #(.DATAWIDTH(16)) bus16 ();

  seq_mul #(.DATAWIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  seq_mul #(.DATAWIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  typedef struct {
    logic [31:0] prod;
    int          edge_n;   // posedge that samples start
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endfunction

  function automatic void fail_event(input string name);
    checks++;
    $display("FAIL %s", name);
  endfunction

  // ---------------- monitors / scoreboard ----------------
  initial begin : mon8
    logic [15:0] last_prod;
    int          busy_cnt;
    exp_t        e;
    last_prod = '0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_prod = '0;
        busy_cnt  = 0;
      end else begin
        if (bus8.busy) busy_cnt++;
        if (bus8.done) begin
          if (q8.size() == 0) begin
            fail_event($sformatf("dut8 unexpected done at edge %0d, prod=%0d", cyc, bus8.prod));
          end else begin
            e = q8.pop_front();
            $display("dut8 %s: prod=%0d, sampled edge %0d, done seen after edge %0d",
                     e.name, bus8.prod, e.edge_n, cyc);
            check({"dut8 prod ", e.name}, 32'(bus8.prod), e.prod);
            check({"dut8 latency ", e.name}, cyc, e.edge_n + 8);
            check({"dut8 busy cycles ", e.name}, busy_cnt, 8);
          end
          busy_cnt  = 0;
          last_prod = bus8.prod;
        end else if (bus8.prod !== last_prod) begin
          check("dut8 prod hold", 32'(bus8.prod), 32'(last_prod));
          last_prod = bus8.prod;
        end
      end
    end
  end

  initial begin : mon16
    logic [31:0] last_prod;
    int          busy_cnt;
    exp_t        e;
    last_prod = '0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_prod = '0;
        busy_cnt  = 0;
      end else begin
        if (bus16.busy) busy_cnt++;
        if (bus16.done) begin
          if (q16.size() == 0) begin
            fail_event($sformatf("dut16 unexpected done at edge %0d, prod=%0d", cyc, bus16.prod));
          end else begin
            e = q16.pop_front();
            $display("dut16 %s: prod=0x%0h, sampled edge %0d, done seen after edge %0d",
                     e.name, bus16.prod, e.edge_n, cyc);
            check({"dut16 prod ", e.name}, bus16.prod, e.prod);
            check({"dut16 latency ", e.name}, cyc, e.edge_n + 16);
            check({"dut16 busy cycles ", e.name}, busy_cnt, 16);
          end
          busy_cnt  = 0;
          last_prod = bus16.prod;
        end else if (bus16.prod !== last_prod) begin
          check("dut16 prod hold", bus16.prod, last_prod);
          last_prod = bus16.prod;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic push8(input logic [31:0] p, input string nm);
    exp_t e;
    e.prod   = p;
    e.edge_n = cyc + 1;
    e.name   = nm;
    q8.push_back(e);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [31:0] p, input string nm);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    push8(p, nm);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input string nm);
    exp_t e;
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    e.prod   = p;
    e.edge_n = cyc + 1;
    e.name   = nm;
    q16.push_back(e);
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((bus8.busy || bus8.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail_event("dut8 timeout waiting for idle");
  endtask

  task automatic wait_idle16();
    int n = 0;
    while ((bus16.busy || bus16.done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail_event("dut16 timeout waiting for idle");
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n;
    int seen;
    rst_n       = 1'b0;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;

    #1;
    check("reset busy8", 32'(bus8.busy), 0);
    check("reset done8", 32'(bus8.done), 0);
    check("reset prod8", 32'(bus8.prod), 0);
    check("reset busy16", 32'(bus16.busy), 0);
    check("reset done16", 32'(bus16.done), 0);
    check("reset prod16", bus16.prod, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, maximum (carry) and zero operands.
    issue8(8'd13, 8'd11, 32'd143, "13x11");
    wait_idle8();
    issue8(8'd255, 8'd255, 32'd65025, "255x255");
    wait_idle8();
    issue8(8'd0, 8'd200, 32'd0, "0x200");
    wait_idle8();
    issue8(8'd200, 8'd1, 32'd200, "200x1");
    wait_idle8();

    // start held while busy with changing operands: must be ignored.
    issue8(8'd100, 8'd3, 32'd300, "100x3 start-while-busy");
    n = 0;
    while (bus8.busy && n < 20) begin
      bus8.start = 1'b1;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      @(negedge clk);
      n++;
    end
    bus8.start = 1'b0;
    wait_idle8();

    // Back-to-back: start held through DONE picks up 7x6 with no IDLE gap.
    bus8.start = 1'b1;
    bus8.a     = 8'd9;
    bus8.b     = 8'd9;
    push8(32'd81, "9x9 b2b-first");
    @(negedge clk);
    bus8.a = 8'd7;
    bus8.b = 8'd6;
    n = 0;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_event("dut8 timeout waiting for done (b2b)");
    push8(32'd42, "7x6 b2b-second");
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle8();

    // Reset mid-operation at RUN cycle 4: immediate clear, no done.
    issue8(8'd200, 8'd100, 32'd20000, "200x100 aborted");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy8", 32'(bus8.busy), 0);
    check("async reset done8", 32'(bus8.done), 0);
    check("async reset prod8", 32'(bus8.prod), 0);
    q8.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    seen = 0;
    repeat (12) begin
      if (bus8.done) seen++;
      @(negedge clk);
    end
    check("no done after reset", 32'(seen), 0);

    issue8(8'd3, 8'd5, 32'd15, "3x5 after reset");
    wait_idle8();

    // 16-bit instance.
    issue16(16'hFFFF, 16'h0002, 32'h0001FFFE, "FFFFx0002");
    wait_idle16();
    issue16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "FFFFxFFFF");
    wait_idle16();

    // Drain any outstanding expectations.
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (q8.size() != 0) begin
      fail_event({"dut8 missing result ", q8[0].name});
      void'(q8.pop_front());
    end
    while (q16.size() != 0) begin
      fail_event({"dut16 missing result ", q16[0].name});
      void'(q16.pop_front());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
